// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-requester AXI command arbiter.
// Holds the FSM state encoding, the response codes and the command record.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic [1:0] OKAY         = 2'b00;
    localparam logic [1:0] TIMEOUT_RESP = 2'b11;

    localparam int unsigned DEFAULT_TIMEOUT = 256;

    typedef struct packed {
        logic        wr;
        logic [23:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [31:0] din;
        logic [3:0]  strb;
    } cmd_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/axi_rr_arb2.sv
// Two-way round-robin pick: a lone request wins outright; on a tie the
// requester that was not granted last wins.
module axi_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        valid = |req;
        grant = 1'b0;
        case (req)
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/axi_cmd_arbiter.sv
// Arbitrates two command requesters onto a single AXI master, one transaction
// at a time, with a wait timeout and saturating per-requester grant counters.
module axi_cmd_arbiter
    import axi_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        m_axi_aclk,
    input  logic        m_axi_aresetn,
    input  logic        req0,
    input  logic        req1,
    input  logic        op0,
    input  logic        op1,
    input  logic [23:0] addr0,
    input  logic [23:0] addr1,
    input  logic [7:0]  len0,
    input  logic [7:0]  len1,
    input  logic [1:0]  burst0,
    input  logic [1:0]  burst1,
    input  logic [31:0] din0,
    input  logic [31:0] din1,
    input  logic [3:0]  strb0,
    input  logic [3:0]  strb1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [1:0]  resp_o,
    output logic [31:0] rdata_o,
    output logic        mst_start,
    output logic        mst_wr,
    output logic [23:0] mst_addr,
    output logic [7:0]  mst_len,
    output logic [1:0]  mst_burst,
    output logic [31:0] mst_din,
    output logic [3:0]  mst_strb,
    input  logic        mst_done,
    input  logic [1:0]  mst_resp,
    input  logic [31:0] mst_rdata,
    output logic        busy,
    output logic [15:0] gcnt0,
    output logic [15:0] gcnt1
);

    // Last WAIT cycle count before the abort is taken.
    localparam logic [15:0] TCNT_LAST = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic        gidx_q, gidx_d;
    cmd_t        cmd_q, cmd_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  done_q, done_d;
    logic        start_q, start_d;
    logic        busy_q, busy_d;
    logic [1:0]  resp_q, resp_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic [15:0] gcnt0_q, gcnt0_d;
    logic [15:0] gcnt1_q, gcnt1_d;

    logic arb_grant;
    logic arb_valid;
    cmd_t cmd0, cmd1;

    assign cmd0 = '{wr: op0, addr: addr0, len: len0, burst: burst0, din: din0, strb: strb0};
    assign cmd1 = '{wr: op1, addr: addr1, len: len1, burst: burst1, din: din1, strb: strb1};

    axi_rr_arb2 u_rr (
        .req   ({req1, req0}),
        .last  (last_q),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gidx_d  = gidx_q;
        cmd_d   = cmd_q;
        gnt_d   = 2'b00;
        done_d  = 2'b00;
        start_d = 1'b0;
        resp_d  = resp_q;
        rdata_d = rdata_q;
        tcnt_d  = tcnt_q;
        gcnt0_d = gcnt0_q;
        gcnt1_d = gcnt1_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    gidx_d           = arb_grant;
                    cmd_d            = arb_grant ? cmd1 : cmd0;
                    gnt_d[arb_grant] = 1'b1;
                    if (arb_grant) gcnt1_d = sat_inc16(gcnt1_q);
                    else           gcnt0_d = sat_inc16(gcnt0_q);
                    state_d          = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                start_d = 1'b1;
                tcnt_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion in the same cycle as the timeout takes precedence.
                if (mst_done) begin
                    resp_d          = mst_resp;
                    rdata_d         = mst_rdata;
                    done_d[gidx_q]  = 1'b1;
                    state_d         = ST_RESP;
                end else if (tcnt_q == TCNT_LAST) begin
                    resp_d          = TIMEOUT_RESP;
                    rdata_d         = '0;
                    done_d[gidx_q]  = 1'b1;
                    state_d         = ST_RESP;
                end else begin
                    tcnt_d = tcnt_q + 16'd1;
                end
            end
            ST_RESP: begin
                last_d  = gidx_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge m_axi_aclk) begin
        if (!m_axi_aresetn) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            gidx_q  <= 1'b0;
            cmd_q   <= '0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            resp_q  <= OKAY;
            rdata_q <= '0;
            tcnt_q  <= '0;
            gcnt0_q <= '0;
            gcnt1_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gidx_q  <= gidx_d;
            cmd_q   <= cmd_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
            tcnt_q  <= tcnt_d;
            gcnt0_q <= gcnt0_d;
            gcnt1_q <= gcnt1_d;
        end
    end

    assign gnt0      = gnt_q[0];
    assign gnt1      = gnt_q[1];
    assign done0     = done_q[0];
    assign done1     = done_q[1];
    assign resp_o    = resp_q;
    assign rdata_o   = rdata_q;
    assign mst_start = start_q;
    assign mst_wr    = cmd_q.wr;
    assign mst_addr  = cmd_q.addr;
    assign mst_len   = cmd_q.len;
    assign mst_burst = cmd_q.burst;
    assign mst_din   = cmd_q.din;
    assign mst_strb  = cmd_q.strb;
    assign busy      = busy_q;
    assign gcnt0     = gcnt0_q;
    assign gcnt1     = gcnt1_q;

endmodule

// File: tb/tb_axi_cmd_arbiter.sv
// Directed self-checking bench for axi_cmd_arbiter: write, read, timeout,
// ignored completion, mid-transaction reset, contention and counter saturation.
module tb_axi_cmd_arbiter;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, op0, op1;
    logic [23:0] addr0, addr1;
    logic [7:0]  len0, len1;
    logic [1:0]  burst0, burst1;
    logic [31:0] din0, din1;
    logic [3:0]  strb0, strb1;
    logic        gnt0, gnt1, done0, done1;
    logic [1:0]  resp_o;
    logic [31:0] rdata_o;
    logic        mst_start, mst_wr;
    logic [23:0] mst_addr;
    logic [7:0]  mst_len;
    logic [1:0]  mst_burst;
    logic [31:0] mst_din;
    logic [3:0]  mst_strb;
    logic        mst_done;
    logic [1:0]  mst_resp;
    logic [31:0] mst_rdata;
    logic        busy;
    logic [15:0] gcnt0, gcnt1;

    int n_cmp = 0;
    int n_mis = 0;

    axi_cmd_arbiter #(.TIMEOUT(TO)) dut (
        .m_axi_aclk    (clk),
        .m_axi_aresetn (rst_n),
        .req0          (req0),
        .req1          (req1),
        .op0           (op0),
        .op1           (op1),
        .addr0         (addr0),
        .addr1         (addr1),
        .len0          (len0),
        .len1          (len1),
        .burst0        (burst0),
        .burst1        (burst1),
        .din0          (din0),
        .din1          (din1),
        .strb0         (strb0),
        .strb1         (strb1),
        .gnt0          (gnt0),
        .gnt1          (gnt1),
        .done0         (done0),
        .done1         (done1),
        .resp_o        (resp_o),
        .rdata_o       (rdata_o),
        .mst_start     (mst_start),
        .mst_wr        (mst_wr),
        .mst_addr      (mst_addr),
        .mst_len       (mst_len),
        .mst_burst     (mst_burst),
        .mst_din       (mst_din),
        .mst_strb      (mst_strb),
        .mst_done      (mst_done),
        .mst_resp      (mst_resp),
        .mst_rdata     (mst_rdata),
        .busy          (busy),
        .gcnt0         (gcnt0),
        .gcnt1         (gcnt1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic simple_txn0();
        req0 = 1'b1;
        op0  = 1'b0;
        tick();
        req0 = 1'b0;
        tick();
        tick();
        mst_done = 1'b1;
        mst_resp = 2'b00;
        tick();
        mst_done = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        logic [1:0] exp_v;

        rst_n = 1'b0;
        {req0, req1, op0, op1} = '0;
        addr0 = '0; addr1 = '0; len0 = '0; len1 = '0;
        burst0 = '0; burst1 = '0; din0 = '0; din1 = '0;
        strb0 = '0; strb1 = '0;
        mst_done = 1'b0; mst_resp = '0; mst_rdata = '0;

        // Reset state
        tick(); tick();
        check("rst_ctrl", {busy, gnt1, gnt0, done1, done0, mst_start}, 6'b0);
        check("rst_gcnt", {gcnt1, gcnt0}, 32'h0);
        check("rst_resp", {resp_o, rdata_o}, 34'h0);
        rst_n = 1'b1;
        tick();

        // Single write from requester 0
        req0 = 1'b1; op0 = 1'b1; addr0 = 24'h000100; len0 = 8'd3;
        burst0 = 2'b01; din0 = 32'hA5A5_0001; strb0 = 4'hF;
        tick();
        check("wr_gnt", {gnt1, gnt0}, 2'b01);
        check("wr_addr", mst_addr, 24'h000100);
        check("wr_cmd", {mst_wr, mst_len, mst_burst, mst_strb, mst_din},
              {1'b1, 8'd3, 2'b01, 4'hF, 32'hA5A5_0001});
        check("wr_busy", busy, 1'b1);
        req0 = 1'b0;
        tick();
        check("wr_start", {mst_start, gnt0}, 2'b10);
        check("wr_gcnt0", gcnt0, 16'd1);
        tick();
        check("wr_start_pulse", mst_start, 1'b0);
        repeat (7) tick();
        mst_done = 1'b1; mst_resp = 2'b00; mst_rdata = 32'h1111_2222;
        tick();
        mst_done = 1'b0;
        check("wr_done", {done1, done0}, 2'b01);
        check("wr_resp", resp_o, 2'b00);
        check("wr_addr_hold", mst_addr, 24'h000100);
        tick();
        check("wr_idle", {busy, done1, done0}, 3'b000);

        // Single read from requester 1
        req1 = 1'b1; op1 = 1'b0; addr1 = 24'h00ABCD; len1 = 8'd0;
        burst1 = 2'b10; din1 = 32'h0; strb1 = 4'h0;
        tick();
        check("rd_gnt", {gnt1, gnt0}, 2'b10);
        check("rd_cmd", {mst_wr, mst_addr}, {1'b0, 24'h00ABCD});
        req1 = 1'b0;
        tick();
        check("rd_start", mst_start, 1'b1);
        tick();
        mst_done = 1'b1; mst_resp = 2'b10; mst_rdata = 32'hDEADBEEF;
        tick();
        mst_done = 1'b0;
        check("rd_done", {done1, done0}, 2'b10);
        check("rd_rdata", rdata_o, 32'hDEADBEEF);
        check("rd_resp", resp_o, 2'b10);
        check("rd_gcnt1", gcnt1, 16'd1);
        tick();
        check("rd_idle", busy, 1'b0);

        // Timeout on requester 0: done0 sixteen cycles after WAIT entry
        req0 = 1'b1; op0 = 1'b1; addr0 = 24'h000200;
        tick();
        check("to_gnt", {gnt1, gnt0}, 2'b01);
        req0 = 1'b0;
        tick();
        check("to_start", mst_start, 1'b1);
        n = 0;
        while (done0 !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("to_latency", n, 16);
        check("to_resp", resp_o, 2'b11);
        check("to_rdata", rdata_o, 32'h0);
        tick();

        // Completion outside WAIT is ignored
        mst_done = 1'b1; mst_resp = 2'b01; mst_rdata = 32'h0000CAFE;
        tick();
        mst_done = 1'b0;
        check("idle_done_ign", {busy, done1, done0}, 3'b000);
        check("idle_done_cap", {resp_o, rdata_o}, {2'b11, 32'h0});

        // Reset in the middle of WAIT
        req0 = 1'b1; op0 = 1'b1; addr0 = 24'h000300; len0 = 8'd7;
        tick();
        req0 = 1'b0;
        tick(); tick(); tick();
        check("mid_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_ctrl", {busy, gnt1, gnt0, done1, done0, mst_start}, 6'b0);
        check("mid_rst_cmd", {mst_wr, mst_addr, mst_len, mst_burst, mst_strb, mst_din}, 71'h0);
        check("mid_rst_resp", {resp_o, rdata_o}, 34'h0);
        check("mid_rst_gcnt", {gcnt1, gcnt0}, 32'h0);
        tick();
        mst_done = 1'b1; mst_resp = 2'b01; mst_rdata = 32'h5555_AAAA;
        tick();
        mst_done = 1'b0;
        check("mid_late_done", {busy, done1, done0}, 3'b000);
        check("mid_late_resp", {resp_o, rdata_o}, 34'h0);

        // Contention: both held high for four transactions
        addr0 = 24'h000010; addr1 = 24'h000020;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_v = (i % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            check($sformatf("rr_gnt%0d", i), {gnt1, gnt0}, exp_v);
            check($sformatf("rr_addr%0d", i), mst_addr, (i % 2 == 0) ? 24'h000010 : 24'h000020);
            if (i == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            tick();
            check($sformatf("rr_start%0d", i), mst_start, 1'b1);
            tick();
            mst_done = 1'b1; mst_resp = 2'b00; mst_rdata = 32'h100 + i;
            tick();
            mst_done = 1'b0;
            check($sformatf("rr_done%0d", i), {done1, done0}, exp_v);
            tick();
            check($sformatf("rr_gap%0d", i), {busy, gnt1, gnt0}, 3'b000);
        end
        check("rr_gcnt", {gcnt1, gcnt0}, {16'd2, 16'd2});

        // Saturation of gcnt0
        force dut.gcnt0_q = 16'hFFFE;
        tick();
        release dut.gcnt0_q;
        tick();
        check("sat_preload", gcnt0, 16'hFFFE);
        simple_txn0();
        check("sat_first", gcnt0, 16'hFFFF);
        simple_txn0();
        check("sat_hold", gcnt0, 16'hFFFF);
        check("sat_gcnt1", gcnt1, 16'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
